master_i2c: RTL
===============

Name: master_i2c

Overview:
Single-master I2C controller, the initiator counterpart to the on-chip I2C slave. Performs one single-byte transaction per command: START, 7-bit address + R/W, address ACK, one data byte (write or read), ACK/NACK, STOP. Drives SCL and SDA open-drain (pull low or release) from one system clock. Sits between host control logic and the shared I2C bus pins.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles; legal range 2..255.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  command strobe; sampled only when busy=0
addr  input  7  target device address, latched on accepted start
rw  input  1  0 = write, 1 = read; latched on accepted start
wdata  input  8  write byte, latched on accepted start
rdata  output  8  byte received in a read; valid when done=1, held until next accepted start
busy  output  1  high from cycle after accepted start until the cycle done pulses (inclusive)
done  output  1  one-cycle pulse at end of STOP
ack_err  output  1  set with done if address or write-data NACKed; held until next accepted start
scl  inout  1  open-drain: drive 0 or release (z)
sda  inout  1  open-drain: drive 0 or release (z)

Behaviour:
- Reset (synchronous, rst=1 on a clk edge): state IDLE, scl and sda released, busy=0, done=0, ack_err=0, rdata=0x00, divider and bit counters cleared. Reset mid-transaction releases both lines on the next edge; no STOP is generated and no bus recovery is attempted.
- Quarter-phase timer: counter 0..CLK_DIV-1; wrap produces tick, advancing phase q0..q3. Phase counter only runs while busy.
- Bit slot (4 quarters): q0 SCL low, SDA updated at entry; q1,q2 SCL released; SDA sampled on first clk of q2; q3 SCL low.
- State machine: IDLE -> START -> ADDR -> ACK1 -> DATA -> ACK2 -> STOP -> IDLE.
  IDLE: both released; start && !busy latches addr/rw/wdata, clears ack_err, enters START.
  START: q0,q1 SDA released, SCL released from q1; q2 SDA pulled low while SCL high; q3 SCL low.
  ADDR: 8 bit slots, MSB first, {addr, rw}; bit=1 releases SDA, bit=0 drives 0.
  ACK1: SDA released; sample in q2. Sample 0 -> DATA. Sample 1 -> ack_err=1, skip to STOP.
  DATA write: 8 slots of wdata MSB first. DATA read: SDA released, 8 samples shifted MSB first into shift register.
  ACK2 write: SDA released, sample; 1 -> ack_err=1. ACK2 read: master drives NACK (SDA released), no sample.
  STOP: q0,q1 SDA driven 0 (SCL rises in q1); q2 SDA released while SCL high; q3 lines released; at end of q3 rdata updates (read), done pulses, busy drops next cycle, IDLE.
- Latency: accepted start to done = 20 bit slots = 80*CLK_DIV cycles (+1 accept cycle); address NACK = 11 slots = 44*CLK_DIV (+1).
- start while busy ignored; no queuing. start in same cycle done pulses ignored.
- No clock stretching, no arbitration: SCL never sampled. Bus assumed idle on start.
- Bit counter 0..7, 3 bits, wraps only via state change.

Decomposition:
- Shared package i2c_pkg: state encodings (IDLE..STOP, 3 bits), phase encodings Q0..Q3, ACK=0/NACK=1 constants, shared with the slave.
- One sub-module: i2c_phase_gen (CLK_DIV counter + 2-bit phase, outputs tick and phase; enable and sync clear inputs).

Test Plan:
- Write: CLK_DIV=4, bench responder at 0x2A ACKs all; start with addr=0x2A, rw=0, wdata=0xA5 -> SDA bits 0x54 then 0xA5, done after 321 cycles, ack_err=0, responder holds 0xA5.
- Read: responder at 0x2A returns 0x3C -> SDA address byte 0x55, rdata=0x3C at done, master releases SDA (NACK) in ACK2 slot, ack_err=0.
- Address NACK: addr=0x11, no responder -> ack_err=1, STOP immediately after ACK1, done after 177 cycles, no data slots on bus.
- Write-data NACK: responder ACKs address, NACKs data, wdata=0xFF -> full 20 slots, ack_err=1.
- Protocol checks: START = SDA falling while SCL high; STOP = SDA rising while SCL high; SDA never changes while SCL high otherwise; start pulses while busy produce no second transaction.
- Reset mid-ADDR: assert rst at bit 3 -> next edge scl=z, sda=z, busy=0, done=0; fresh start afterwards completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state, phase and acknowledge encodings shared by the I2C master and slave
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} phase_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_phase_gen.sv
// i2c_phase_gen: divides clk into SCL quarter phases q0..q3
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  logic   clr,
  output logic   tick,
  output phase_t phase
);
  logic [7:0] cnt;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 8'd1;
      if (tick) phase <= phase_t'(phase + 2'd1);
    end
endmodule

// File: rtl/master_i2c.sv
// master_i2c: single-byte I2C master, one START/addr/data/STOP transaction per command
module master_i2c
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);
  state_t     state;
  phase_t     phase;
  logic       tick, tick_d, slot_end, sample, scl_r, sda_r, scl_n, sda_n;
  logic       rw_q, ack_bit, nack_seen;
  logic [2:0] bit_cnt;
  logic [7:0] shift, wdata_q;
  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .tick (tick),
    .phase(phase)
  );
  assign slot_end = tick && phase == Q3;
  assign sample   = tick_d && phase == Q2;
  assign scl = scl_r ? 1'bz : 1'b0;
  assign sda = sda_r ? 1'bz : 1'b0;
  // Line levels for the current state/phase; registered so both pins change one cycle later together
  always_comb begin
    scl_n = state == IDLE || (state == STOP ? phase != Q0 : phase == Q1 || phase == Q2);
    sda_n = state == START ? phase <= Q1 :
            state == ADDR || (state == DATA && !rw_q) ? shift[7] :
            state == STOP ? phase >= Q2 : 1'b1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      scl_r     <= 1'b1;
      sda_r     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rdata     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      ack_bit   <= 1'b0;
      nack_seen <= 1'b0;
      tick_d    <= 1'b0;
    end else begin
      scl_r  <= scl_n;
      sda_r  <= sda_n;
      tick_d <= tick;
      done   <= 1'b0;
      if (sample) ack_bit <= sda;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            state     <= START;
            busy      <= 1'b1;
            ack_err   <= 1'b0;
            nack_seen <= 1'b0;
            bit_cnt   <= '0;
            shift     <= {addr, rw};
            rw_q      <= rw;
            wdata_q   <= wdata;
          end
        end
        START: if (slot_end) state <= ADDR;
        ADDR: if (slot_end) begin
          shift   <= shift << 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ACK1;
        end
        ACK1: if (slot_end) begin
          shift <= wdata_q;
          state <= ack_bit == ACK ? DATA : STOP;
          if (ack_bit == NACK) nack_seen <= 1'b1;
        end
        DATA: begin
          if (sample && rw_q) shift <= {shift[6:0], sda};
          if (slot_end) begin
            if (!rw_q) shift <= shift << 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ACK2;
          end
        end
        ACK2: if (slot_end) begin
          state <= STOP;
          if (!rw_q && ack_bit == NACK) nack_seen <= 1'b1;
        end
        STOP: if (slot_end) begin
          state   <= IDLE;
          done    <= 1'b1;
          ack_err <= nack_seen;
          if (rw_q) rdata <= shift;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
